// File: rtl/pipeline_perf_monitor_if.sv
// Read-port bundle for pipeline_perf_monitor: a host issues register reads,
// the monitor answers one cycle later with a data/valid pair.
interface pipeline_perf_monitor_if #(
  parameter int unsigned CNT_W = 32
) ();

  logic             rd_en;
  logic [2:0]       rd_addr;
  logic [CNT_W-1:0] rd_data;
  logic             rd_valid;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    input  rd_valid
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    output rd_valid
  );

endinterface

// File: rtl/pipeline_perf_monitor.sv
// pipeline_perf_monitor: cycle/retire/stall counters, idle-loop detector with
// sticky halt, and a registered read port for software or a debug host.
// Optional BRANCHES counter at address 5 is built when PERF_MON_BRANCH_CNT_EN
// is defined; otherwise branch_in is ignored and address 5 reads zero.
module pipeline_perf_monitor #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned HIST_DEPTH = 16,
  parameter int unsigned MATCH_MULT = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mon_en,
  input  logic                    mon_clr,
  input  logic [31:0]             pc_in,
  input  logic [31:0]             instr_in,
  input  logic                    stall_in,
  input  logic                    branch_in,
  pipeline_perf_monitor_if.slave  rd_bus,
  output logic                    halted
);

  localparam int unsigned NP     = 4;
  localparam int unsigned PTR_W  = $clog2(HIST_DEPTH);
  localparam int unsigned FILL_W = $clog2(HIST_DEPTH + 1);
  localparam int unsigned THR1   = (MATCH_MULT * 1 > 3) ? MATCH_MULT * 1 : 3;
  localparam int unsigned THR2   = (MATCH_MULT * 2 > 3) ? MATCH_MULT * 2 : 3;
  localparam int unsigned THR3   = (MATCH_MULT * 3 > 3) ? MATCH_MULT * 3 : 3;
  localparam int unsigned THR4   = (MATCH_MULT * 4 > 3) ? MATCH_MULT * 4 : 3;
  // Thresholds grow with the period, so the longest one sizes the match counters.
  localparam int unsigned MC_W   = $clog2(THR4 + 1);
  localparam int unsigned THR [NP] = '{THR1, THR2, THR3, THR4};

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } mon_state_e;

  mon_state_e        r_state;
  mon_state_e        w_state_nxt;

  logic [CNT_W-1:0]  r_cycles;
  logic [CNT_W-1:0]  r_instret;
  logic [CNT_W-1:0]  r_stalls;
  logic [CNT_W-1:0]  w_branches;

  logic [31:0]       r_hist [HIST_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [FILL_W-1:0] r_fill;
  logic [31:0]       r_prev_instr;
  logic [MC_W-1:0]   r_mcnt [NP];
  logic [2:0]        r_loop_period;
  logic [31:0]       r_halt_pc;

  logic [CNT_W-1:0]  r_rd_data;
  logic              r_rd_valid;

  logic              w_active;
  logic              w_sample;
  logic              w_match    [NP];
  logic [MC_W-1:0]   w_mcnt_nxt [NP];
  logic              w_hit_any;
  logic [2:0]        w_hit_period;
  logic [CNT_W-1:0]  w_rd_mux;

  assign halted          = (r_state == ST_HALT);
  assign rd_bus.rd_data  = r_rd_data;
  assign rd_bus.rd_valid = r_rd_valid;

  // Halt state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus active/sample qualifiers; a clear always returns to RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_active    = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_active = mon_en & ~mon_clr;
        w_sample = mon_en & ~mon_clr & ~stall_in;
        if (w_sample && w_hit_any) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (mon_clr) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Per-period match against pre-write history; smallest period over threshold wins.
  always_comb begin
    w_hit_any    = 1'b0;
    w_hit_period = '0;
    for (int p = 0; p < NP; p++) begin
      w_match[p] = (r_fill >= FILL_W'(p + 1)) &&
                   (pc_in == r_hist[r_wptr - PTR_W'(p + 1)]);
      if (p == 0) begin
        w_match[p] = w_match[p] && (instr_in == r_prev_instr);
      end
      w_mcnt_nxt[p] = w_match[p] ? (r_mcnt[p] + MC_W'(1)) : '0;
    end
    for (int p = int'(NP) - 1; p >= 0; p--) begin
      if (w_match[p] && (w_mcnt_nxt[p] >= MC_W'(THR[p]))) begin
        w_hit_any    = 1'b1;
        w_hit_period = 3'(p + 1);
      end
    end
  end

  // Free-running performance counters, frozen outside active cycles.
  always_ff @(posedge clock) begin
    if (!reset || mon_clr) begin
      r_cycles  <= '0;
      r_instret <= '0;
      r_stalls  <= '0;
    end else if (w_active) begin
      r_cycles <= r_cycles + CNT_W'(1);
      if (!stall_in && (instr_in != NOP_INSTR)) begin
        r_instret <= r_instret + CNT_W'(1);
      end
      if (stall_in) begin
        r_stalls <= r_stalls + CNT_W'(1);
      end
    end
  end

`ifdef PERF_MON_BRANCH_CNT_EN
  logic [CNT_W-1:0] r_branches;

  // Taken branches on non-stalled active cycles.
  always_ff @(posedge clock) begin
    if (!reset || mon_clr) begin
      r_branches <= '0;
    end else if (w_sample && branch_in) begin
      r_branches <= r_branches + CNT_W'(1);
    end
  end

  assign w_branches = r_branches;
`else
  logic w_unused_branch;

  assign w_unused_branch = branch_in;
  assign w_branches      = '0;
`endif

  // Detector bookkeeping: pointer, fill level, previous instr and match counters.
  always_ff @(posedge clock) begin
    if (!reset || mon_clr) begin
      r_wptr       <= '0;
      r_fill       <= '0;
      r_prev_instr <= '0;
      for (int p = 0; p < NP; p++) begin
        r_mcnt[p] <= '0;
      end
    end else if (w_sample) begin
      r_wptr       <= r_wptr + PTR_W'(1);
      r_prev_instr <= instr_in;
      if (r_fill != FILL_W'(HIST_DEPTH)) begin
        r_fill <= r_fill + FILL_W'(1);
      end
      for (int p = 0; p < NP; p++) begin
        r_mcnt[p] <= w_mcnt_nxt[p];
      end
    end
  end

  // History storage; entries beyond the fill level are never compared.
  always_ff @(posedge clock) begin
    if (reset && w_sample) begin
      r_hist[r_wptr] <= pc_in;
    end
  end

  // Loop period and PC captured on the halting sample.
  always_ff @(posedge clock) begin
    if (!reset || mon_clr) begin
      r_loop_period <= '0;
      r_halt_pc     <= '0;
    end else if (w_sample && w_hit_any) begin
      r_loop_period <= w_hit_period;
      r_halt_pc     <= pc_in;
    end
  end

  // Register map decode from current (pre-update) state.
  always_comb begin
    w_rd_mux = '0;
    case (rd_bus.rd_addr)
      3'd0:    w_rd_mux = r_cycles;
      3'd1:    w_rd_mux = r_instret;
      3'd2:    w_rd_mux = r_stalls;
      3'd3:    w_rd_mux = CNT_W'({r_loop_period, halted});
      3'd4:    w_rd_mux = CNT_W'(r_halt_pc);
      3'd5:    w_rd_mux = w_branches;
      default: w_rd_mux = '0;
    endcase
  end

  // One-cycle read response; data holds between reads.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_bus.rd_en;
      if (rd_bus.rd_en) begin
        r_rd_data <= w_rd_mux;
      end
    end
  end

endmodule
